// File: rtl/fir_decimator.sv
// Decimate, round/saturate and FIFO-buffer the FIR output stream.
// Define FIR_DEC_AVG_EN for a boxcar-averaging decimator instead of pick-one.
module fir_decimator #(
  parameter int DATA_W     = 22,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_en,
  input  logic signed [DATA_W-1:0]       x_in,
  input  logic                           clear_flags,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           sat_sticky,
  output logic                           drop_sticky
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;

  localparam logic signed [DATA_W:0] RND   = (DATA_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [DATA_W:0] MAX_V = (DATA_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W:0] MIN_V = ~MAX_V;

  logic [PH_W-1:0]          phase_q, phase_d;
  logic                     last_phase_s;
  logic                     keep_s;
  logic signed [DATA_W-1:0] keep_data_s;
  logic                     s1_vld_q;
  logic signed [DATA_W-1:0] s1_data_q;
  logic signed [DATA_W:0]   rnd_sum_s, rnd_s;
  logic signed [OUT_W-1:0]  res_s;
  logic                     clip_s;

  logic signed [OUT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]            rd_q, wr_q;
  logic [LW-1:0]            cnt_q, cnt_d;
  logic signed [OUT_W-1:0]  last_q;
  logic                     empty_s, full_s, pop_s, push_s, drop_s;
  logic                     sat_q, sat_d, drop_q, drop_d;

  assign last_phase_s = (phase_q == PH_W'(DECIM - 1));

  always_comb begin
    phase_d = phase_q;
    if (sample_en) begin
      if (last_phase_s) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end else begin
      phase_d = phase_q;
    end
  end

`ifdef FIR_DEC_AVG_EN
  localparam int LOG_D = $clog2(DECIM);
  localparam int ACC_W = DATA_W + LOG_D;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum_s, acc_avg_s;

  // The closing sample of a group is summed in the same cycle it is emitted.
  assign acc_sum_s   = acc_q + ACC_W'(x_in);
  assign acc_avg_s   = acc_sum_s >>> LOG_D;
  assign keep_s      = sample_en && last_phase_s;
  assign keep_data_s = acc_avg_s[DATA_W-1:0];

  always_comb begin
    acc_d = acc_q;
    if (sample_en) begin
      if (last_phase_s) begin
        acc_d = '0;
      end else begin
        acc_d = acc_sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign keep_s      = sample_en && (phase_q == '0);
  assign keep_data_s = x_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      phase_q   <= phase_d;
      s1_vld_q  <= keep_s;
      s1_data_q <= keep_s ? keep_data_s : s1_data_q;
    end
  end

  // Round half up one bit wider than the input so the bias cannot overflow.
  assign rnd_sum_s = (DATA_W+1)'(s1_data_q) + RND;
  assign rnd_s     = rnd_sum_s >>> SHIFT;

  always_comb begin
    res_s  = rnd_s[OUT_W-1:0];
    clip_s = 1'b0;
    if (rnd_s > MAX_V) begin
      res_s  = MAX_V[OUT_W-1:0];
      clip_s = 1'b1;
    end else if (rnd_s < MIN_V) begin
      res_s  = MIN_V[OUT_W-1:0];
      clip_s = 1'b1;
    end else begin
      res_s  = rnd_s[OUT_W-1:0];
      clip_s = 1'b0;
    end
  end

  assign empty_s = (cnt_q == '0);
  assign full_s  = (cnt_q == LW'(FIFO_DEPTH));
  assign pop_s   = !empty_s && out_ready;
  assign push_s  = s1_vld_q && (!full_s || pop_s);
  assign drop_s  = s1_vld_q && full_s && !pop_s;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A set condition takes priority over a simultaneous clear.
  always_comb begin
    sat_d  = sat_q;
    drop_d = drop_q;
    if (push_s && clip_s) begin
      sat_d = 1'b1;
    end else if (clear_flags) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
    if (drop_s) begin
      drop_d = 1'b1;
    end else if (clear_flags) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= res_s;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_s) begin
        last_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  // An empty FIFO keeps presenting the most recently consumed sample.
  assign out_data    = empty_s ? last_q : mem_q[rd_q];
  assign out_valid   = !empty_s;
  assign fifo_level  = cnt_q;
  assign sat_sticky  = sat_q;
  assign drop_sticky = drop_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: DECIM=4 and DECIM=1 instances side by side.
module tb_fir_decimator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_flags = 1'b0;

  logic               en4 = 1'b0, rdy4 = 1'b1;
  logic signed [21:0] x4 = '0;
  logic signed [7:0]  od4;
  logic               ov4, sat4, drop4;
  logic [2:0]         lvl4;

  logic               en1 = 1'b0, rdy1 = 1'b1;
  logic signed [21:0] x1 = '0;
  logic signed [7:0]  od1;
  logic               ov1, sat1, drop1;
  logic [2:0]         lvl1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic               en;
    logic signed [21:0] x;
    logic               vld;
    int                 data;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  fir_decimator #(.DATA_W(22), .OUT_W(8), .SHIFT(8), .DECIM(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .sample_en(en4), .x_in(x4), .clear_flags(clear_flags),
    .out_data(od4), .out_valid(ov4), .out_ready(rdy4), .fifo_level(lvl4),
    .sat_sticky(sat4), .drop_sticky(drop4));

  fir_decimator #(.DATA_W(22), .OUT_W(8), .SHIFT(8), .DECIM(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .sample_en(en1), .x_in(x1), .clear_flags(clear_flags),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .fifo_level(lvl1),
    .sat_sticky(sat1), .drop_sticky(drop1));

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b1,  22'sd384, 1'b0,  0};
    tbl[1] = '{1'b1,  22'sd640, 1'b1,  2};
    tbl[2] = '{1'b1,  22'sd0,   1'b0,  2};
    tbl[3] = '{1'b1,  22'sd0,   1'b0,  2};
    tbl[4] = '{1'b1, -22'sd384, 1'b0,  2};
    tbl[5] = '{1'b0,  22'sd0,   1'b1, -1};
    tbl[6] = '{1'b0,  22'sd0,   1'b0, -1};
    tbl[7] = '{1'b0,  22'sd0,   1'b0, -1};

    #12;
    chk("rst_valid", int'(ov4), 0);
    chk("rst_data", int'(od4), 0);
    chk("rst_level", int'(lvl4), 0);
    chk("rst_flags", int'({sat4, drop4}), 0);
    @(negedge clk);
    rst = 1'b0;

`ifndef FIR_DEC_AVG_EN
    // Pick-one decimation by 4 with out_ready held high
    for (int i = 0; i < 8; i++) begin
      en4 = tbl[i].en;
      x4  = tbl[i].x;
      tick();
      chk($sformatf("dec_valid[%0d]", i), int'(ov4), int'(tbl[i].vld));
      chk($sformatf("dec_data[%0d]", i), int'(od4), tbl[i].data);
    end
`endif

    // Saturation, both directions, then clear
    en1 = 1'b1; x1 = 22'h0FFFFF; tick();
    en1 = 1'b0; tick();
    chk("sat_pos_valid", int'(ov1), 1);
    chk("sat_pos_data", int'(od1), 127);
    chk("sat_pos_flag", int'(sat1), 1);
    tick();
    en1 = 1'b1; x1 = -22'sd1048576; tick();
    en1 = 1'b0; tick();
    chk("sat_neg_data", int'(od1), -128);
    clear_flags = 1'b1; tick();
    clear_flags = 1'b0;
    chk("sat_cleared", int'(sat1), 0);

    // Back-pressure: six samples into a four-entry FIFO
    tick();
    rdy1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      en1 = 1'b1; x1 = 22'(256 * i); tick();
    end
    en1 = 1'b0; tick(); tick();
    chk("bp_level", int'(lvl1), 4);
    chk("bp_drop", int'(drop1), 1);
    chk("bp_head", int'(od1), 1);
    rdy1 = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("bp_pop[%0d]", j), int'(od1), j);
      tick();
    end
    chk("bp_empty_valid", int'(ov1), 0);
    chk("bp_empty_data", int'(od1), 4);

    // Full FIFO with a write and a pop in the same cycle
    clear_flags = 1'b1; tick();
    clear_flags = 1'b0;
    chk("drop_cleared", int'(drop1), 0);
    rdy1 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      en1 = 1'b1; x1 = 22'(256 * i); tick();
    end
    en1 = 1'b0; tick();
    chk("fp_level", int'(lvl1), 4);
    en1 = 1'b1; x1 = 22'sd1280; tick();
    en1 = 1'b0; rdy1 = 1'b1; tick();
    rdy1 = 1'b0;
    chk("fp_level_after", int'(lvl1), 4);
    chk("fp_no_drop", int'(drop1), 0);
    rdy1 = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      chk($sformatf("fp_pop[%0d]", j), int'(od1), j);
      tick();
    end
    chk("fp_empty", int'(ov1), 0);

    // Asynchronous reset with three entries queued and one in flight
    rdy1 = 1'b0;
    en1 = 1'b1; x1 = 22'h0FFFFF; tick();
    x1 = 22'sd256; tick();
    x1 = 22'sd512; tick();
    x1 = 22'sd768; tick();
    en1 = 1'b0;
    chk("pre_rst_level", int'(lvl1), 3);
    chk("pre_rst_sat", int'(sat1), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(ov1), 0);
    chk("async_rst_level", int'(lvl1), 0);
    chk("async_rst_flags", int'({sat1, drop1}), 0);
    chk("async_rst_data", int'(od1), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_valid", int'(ov1), 0);
    chk("post_rst_level", int'(lvl1), 0);

`ifdef FIR_DEC_AVG_EN
    // Boxcar average of one group of four
    rdy4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      en4 = 1'b1; x4 = 22'(256 * i); tick();
    end
    en4 = 1'b0;
    chk("avg_not_yet", int'(ov4), 0);
    tick();
    chk("avg_valid", int'(ov4), 1);
    chk("avg_data", int'(od4), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
